// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, types and constants for the 14-bit core
package core_pkg;

    localparam int PC_W        = 11;
    localparam int INSTR_W     = 14;
    localparam int STACK_DEPTH = 8;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_WORD = 14'h0000;

    // Source of the next program counter value
    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_TGT  = 2'd1,
        PC_POP  = 2'd2,
        PC_HOLD = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - ROM fetch bus and decode control bundle of the fetch stage
interface pc_fetch_unit_if;
    import core_pkg::*;

    pc_t    Rom_addr_out;
    instr_t Rom_data_in;
    instr_t ir_out;
    pc_t    pc_out;
    logic   hold;
    logic   jump;
    logic   call;
    logic   ret;
    logic   skip;
    pc_t    target_addr;
    logic   stk_ovf;
    logic   stk_unf;

    // Fetch unit side
    modport master (
        output Rom_addr_out,
        input  Rom_data_in,
        output ir_out,
        output pc_out,
        input  hold,
        input  jump,
        input  call,
        input  ret,
        input  skip,
        input  target_addr,
        output stk_ovf,
        output stk_unf
    );

    // ROM / decode side
    modport slave (
        input  Rom_addr_out,
        output Rom_data_in,
        input  ir_out,
        input  pc_out,
        output hold,
        output jump,
        output call,
        output ret,
        output skip,
        output target_addr,
        input  stk_ovf,
        input  stk_unf
    );

endinterface

// File: rtl/pc_fetch_unit_call_stack.sv
// rtl/pc_fetch_unit_call_stack.sv - circular hardware return stack with sticky overflow/underflow flags
module call_stack
    import core_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  pc_t  push_data,
    output pc_t  top_data,
    output logic ovf,
    output logic unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    // sp points at the next free slot; when full it also points at the oldest entry
    logic [PTR_W-1:0] sp_q;
    logic [PTR_W-1:0] sp_dec;
    logic [PTR_W:0]   count_q;
    pc_t              mem_q [DEPTH];

    assign sp_dec   = sp_q - PTR_W'(1);
    assign top_data = mem_q[sp_dec];

    // Push overwrites the oldest slot when full; pop on empty still wraps the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[sp_q] <= push_data;
            sp_q        <= sp_q + PTR_W'(1);
            if (count_q == FULL) begin
                ovf <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop) begin
            sp_q <= sp_dec;
            if (count_q == '0) begin
                unf <= 1'b1;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC selection and instruction register
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter int     STACK_DEPTH = core_pkg::STACK_DEPTH,
    parameter instr_t NOP_WORD    = core_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_unit_if.master   bus
);

    pc_t     pc_q;
    pc_t     pc_d;
    instr_t  ir_q;
    instr_t  ir_d;
    pc_sel_e sel;
    pc_t     top_data;
    logic    push;
    logic    pop;

    assign bus.Rom_addr_out = pc_q;
    assign bus.pc_out       = pc_q;
    assign bus.ir_out       = ir_q;

    // Only the winning control input acts, stack side effects included
    assign pop  = !bus.hold && bus.ret;
    assign push = !bus.hold && !bus.ret && bus.call;

    // Priority: hold > ret > call > jump > skip > increment
    always_comb begin
        sel = PC_INC;
        if (bus.hold) begin
            sel = PC_HOLD;
        end else if (bus.ret) begin
            sel = PC_POP;
        end else if (bus.call || bus.jump) begin
            sel = PC_TGT;
        end
    end

    // Next PC and IR; any transfer or skip squashes the word already fetched
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        case (sel)
            PC_INC: begin
                pc_d = pc_q + PC_W'(1);
                ir_d = bus.skip ? NOP_WORD : bus.Rom_data_in;
            end
            PC_TGT: begin
                pc_d = bus.target_addr;
                ir_d = NOP_WORD;
            end
            PC_POP: begin
                pc_d = top_data;
                ir_d = NOP_WORD;
            end
            default: begin
                pc_d = pc_q;
                ir_d = ir_q;
            end
        endcase
    end

    // PC and IR registers, frozen while hold is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= '0;
        end else if (sel != PC_HOLD) begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    call_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q),
        .top_data  (top_data),
        .ovf       (bus.stk_ovf),
        .unf       (bus.stk_unf)
    );

endmodule
